dct2d_row_col_sched: RTL and testbench
======================================

Name: dct2d_row_col_sched

Overview:
- Sequences one shared combinational 8-point 1D DCT core (fastDCT8-style: 8 signed inputs, 8 outputs, 9-bit input growth) to compute a full 8x8 2D DCT.
- Row pass: accepts 8 pixel rows, one per handshake, pushes each through the core and stores the scaled results in an internal 8x8 transpose buffer.
- Column pass: reads the buffer column by column, reuses the same core, and emits one scaled coefficient column per output handshake.
- Sits between the pixel block fetcher and the quantiser.

Parameters:
- PIX_W, 8, unsigned pixel width.
- CORE_N, 16, core parameter N; core lanes are CORE_N+1 bits in, CORE_N+10 bits out.
- S1, 2, row-pass right shift (>=1).
- S2, 9, column-pass right shift (>=1).
- OUT_W, 16, signed output coefficient width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  pixel row valid.
- in_ready  out  1  row accepted when in_valid&&in_ready.
- in_data  in  8*PIX_W  unsigned pixels; lane i = bits [i*PIX_W +: PIX_W] = x[i].
- out_valid  out  1  coefficient column valid.
- out_ready  in  1  downstream accept.
- out_data  out  8*OUT_W  signed; lane k = Y[k][c].
- out_col  out  3  column index c of out_data.
- block_done  out  1  one-cycle pulse on handshake of column 7.
- busy  out  1  high whenever state != ROW or row count != 0.
- dct_x  out  8*(CORE_N+1)  core inputs, lane-packed as in_data.
- dct_y  in  8*(CORE_N+10)  core outputs, combinational from dct_x.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=ROW, row_cnt=0, col_cnt=0. Outputs: out_valid=0, out_data=0, out_col=0, block_done=0, busy=0. Transpose buffer contents are don't-care.
- Reset mid-block abandons the block. No partial output is emitted afterwards.
- State ROW:
  - in_ready=1.
  - dct_x lane i = sign-extended (x[i] - 2^(PIX_W-1)).
  - On handshake: buf[row_cnt][k] <= sat_{CORE_N+1}((y[k] + 2^(S1-1)) >>> S1) for k=0..7; row_cnt++.
  - The handshake with row_cnt=7 sets row_cnt=0, col_cnt=0 and moves to COL.
- State COL:
  - in_ready=0.
  - dct_x lane r = buf[r][col_cnt].
  - Load condition: (!out_valid || out_ready). When true: out_data lane k <= sat_OUT_W((y[k] + 2^(S2-1)) >>> S2); out_col <= col_cnt; out_valid <= 1; col_cnt++.
  - The load with col_cnt=7 moves to DRAIN.
  - A column is never skipped or duplicated under any out_ready pattern.
- State DRAIN:
  - in_ready=0; core input don't-care (drive 0).
  - out_valid && out_ready (last column): out_valid <= 0, block_done pulses next cycle, state returns to ROW.
- Output stability: out_data and out_col hold while out_valid && !out_ready.
- Arithmetic:
  - All signed two's complement; >>> is arithmetic, so rounding is half-up toward +inf.
  - sat_W clamps to [-2^(W-1), 2^(W-1)-1].
  - Compute in width CORE_N+11 before shifting so there is no intermediate overflow.
- Latency and throughput:
  - First out_valid occurs 1 cycle after the 8th row handshake.
  - Minimum block period is 17 cycles: 8 row, 8 column, 1 drain.
- in_valid is ignored outside ROW. in_data is sampled only on handshake.

Test Plan:
- All pixels 128 with out_ready=1 -> 8 columns, out_col 0..7 in order, every lane 0, block_done pulse after column 7; out_valid first high 1 cycle after the 8th row handshake.
- All pixels 255, bench core model = fastDCT8 → row DC 65024 stored as 16256 → column 0 lane 0 = 16256. All other lanes match the golden model of the same core and shifts.
- Same block with S2=7 -> column 0 lane 0 saturates to 32767 (65024 unclamped). Negative overflow case clamps to -32768.
- Random blocks with in_valid toggling randomly and out_ready held low for 5 cycles on column 3 -> out_data/out_col stable while stalled; no column lost or duplicated; in_ready=0 throughout COL and DRAIN; results bit-exact to the model.
- rst_n asserted after 4 rows, then a fresh block -> no out_valid from the aborted block; the new block's output is identical to a clean run.
- Back-to-back 3 blocks with in_valid=1 and out_ready=1 -> period exactly 17 cycles per block; busy low only in ROW with row_cnt=0.

Source files
------------

// File: rtl/dct2d_row_col_sched.sv
// dct2d_row_col_sched: 8x8 2D DCT scheduler that time-shares one external 1D DCT core
// between a row pass into a transpose buffer and a column pass out to the quantiser.
module dct2d_row_col_sched #(
    parameter int PIX_W  = 8,
    parameter int CORE_N = 16,
    parameter int S1     = 2,
    parameter int S2     = 9,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*PIX_W-1:0]       in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*OUT_W-1:0]       out_data,
    output logic [2:0]               out_col,
    output logic                     block_done,
    output logic                     busy,
    output logic [8*(CORE_N+1)-1:0]  dct_x,
    input  logic [8*(CORE_N+10)-1:0] dct_y
);
    localparam int XW = CORE_N + 1;
    localparam int YW = CORE_N + 10;
    localparam int CW = CORE_N + 11;
    localparam logic signed [CW-1:0] RND1 = CW'(64'sd1 <<< (S1 - 1));
    localparam logic signed [CW-1:0] RND2 = CW'(64'sd1 <<< (S2 - 1));
    localparam logic signed [CW-1:0] MAX1 = CW'((64'sd1 <<< (XW - 1)) - 64'sd1);
    localparam logic signed [CW-1:0] MAX2 = CW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [CW-1:0] MIN1 = ~MAX1;
    localparam logic signed [CW-1:0] MIN2 = ~MAX2;

    typedef enum logic [1:0] {ROW, COL, DRAIN} state_t;
    state_t state_q, state_d;
    logic [2:0] row_cnt_q, row_cnt_d, col_cnt_q, col_cnt_d, out_col_q, out_col_d;
    logic out_valid_q, out_valid_d, done_q, done_d;
    logic [8*OUT_W-1:0] out_data_q, out_data_d, col_res;
    logic signed [XW-1:0] tbuf_q [8][8];
    logic signed [XW-1:0] row_res [8];

    for (genvar k = 0; k < 8; k++) begin : g_lane
        logic signed [CW-1:0] y, r1, r2;
        logic [PIX_W-1:0] px;
        assign px = in_data[k*PIX_W +: PIX_W];
        assign y  = CW'($signed(dct_y[k*YW +: YW]));
        assign r1 = (y + RND1) >>> S1;
        assign r2 = (y + RND2) >>> S2;
        assign row_res[k] = r1 > MAX1 ? MAX1[XW-1:0] : r1 < MIN1 ? MIN1[XW-1:0] : r1[XW-1:0];
        assign col_res[k*OUT_W +: OUT_W] = r2 > MAX2 ? MAX2[OUT_W-1:0] : r2 < MIN2 ? MIN2[OUT_W-1:0] : r2[OUT_W-1:0];
        // flipping the pixel MSB yields x - 2^(PIX_W-1) as a signed PIX_W-bit value
        assign dct_x[k*XW +: XW] = state_q == ROW ? XW'($signed({~px[PIX_W-1], px[PIX_W-2:0]}))
                                 : state_q == COL ? tbuf_q[k][col_cnt_q] : '0;
    end

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        col_cnt_d   = col_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_col_d   = out_col_q;
        done_d      = 1'b0;
        if (state_q == ROW && in_valid) begin
            row_cnt_d = row_cnt_q + 3'd1;
            col_cnt_d = '0;
            state_d   = row_cnt_q == 3'd7 ? COL : ROW;
        end
        if (state_q == COL && (!out_valid_q || out_ready)) begin
            out_data_d  = col_res;
            out_col_d   = col_cnt_q;
            out_valid_d = 1'b1;
            col_cnt_d   = col_cnt_q + 3'd1;
            state_d     = col_cnt_q == 3'd7 ? DRAIN : COL;
        end
        if (state_q == DRAIN && out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = ROW;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ROW;
            row_cnt_q   <= '0;
            col_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_col_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            col_cnt_q   <= col_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_col_q   <= out_col_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk)
        if (state_q == ROW && in_valid)
            for (int k = 0; k < 8; k++) tbuf_q[row_cnt_q][k] <= row_res[k];

    assign in_ready   = state_q == ROW;
    assign busy       = state_q != ROW || row_cnt_q != 3'd0;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_col    = out_col_q;
    assign block_done = done_q;
endmodule

// File: tb/tb_dct2d_row_col_sched.sv
// tb_dct2d_row_col_sched: directed bench; a matrix-level 2D DCT model checks both DUT
// instances (S2=9 and S2=7) every cycle, plus hand-computed literal pins.
`timescale 1ns/1ps
module tb_dct2d_row_col_sched;
    localparam int XW = 17;
    localparam int YW = 26;
    localparam int C [8][8] = '{
        '{64,  64,  64,  64,  64,  64,  64,  64},
        '{89,  75,  50,  18, -18, -50, -75, -89},
        '{83,  36, -36, -83, -83, -36,  36,  83},
        '{75, -18, -89, -50,  50,  89,  18, -75},
        '{64, -64, -64,  64,  64, -64, -64,  64},
        '{50, -89,  18,  75, -75, -18,  89, -50},
        '{36, -83,  83, -36, -36,  83, -83,  36},
        '{18, -50,  75, -89,  89, -75,  50, -18}};

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [63:0] in_data = '0;
    logic in_ready, out_valid, block_done, busy;
    logic in_ready7, out_valid7, block_done7, busy7;
    logic [127:0] out_data, out_data7;
    logic [2:0] out_col, out_col7;
    logic [8*XW-1:0] dct_x, dct_x7;
    logic [8*YW-1:0] dct_y, dct_y7;

    int total = 0, bad = 0, cyc = 0;
    int blk [8][8];
    int pix [8][8];
    int exp9 [8][8];
    int exp7 [8][8];
    int rows = 0, exp_col = 0, n8 = 0, cap9 = 0, cap7 = 0;
    bit done_exp = 1'b0;
    int done_cyc [$];

    always #5 clk = ~clk;

    dct2d_row_col_sched dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_col(out_col),
        .block_done(block_done), .busy(busy), .dct_x(dct_x), .dct_y(dct_y));

    dct2d_row_col_sched #(.S2(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready7), .in_data(in_data),
        .out_valid(out_valid7), .out_ready(out_ready), .out_data(out_data7), .out_col(out_col7),
        .block_done(block_done7), .busy(busy7), .dct_x(dct_x7), .dct_y(dct_y7));

    function automatic logic [8*YW-1:0] core(input logic [8*XW-1:0] x);
        logic [8*YW-1:0] y;
        longint a;
        y = '0;
        for (int k = 0; k < 8; k++) begin
            a = 0;
            for (int i = 0; i < 8; i++) a += longint'(C[k][i]) * longint'($signed(x[i*XW +: XW]));
            y[k*YW +: YW] = a[YW-1:0];
        end
        return y;
    endfunction

    always_comb dct_y = core(dct_x);
    always_comb dct_y7 = core(dct_x7);

    function automatic longint rnd_sat(input longint v, input int s, input int w);
        longint r, mx;
        r  = (v + (64'sd1 <<< (s - 1))) >>> s;
        mx = (64'sd1 <<< (w - 1)) - 1;
        return r > mx ? mx : r < -mx - 1 ? -mx - 1 : r;
    endfunction

    function automatic void build();
        int t [8][8];
        longint a;
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) begin
                a = 0;
                for (int i = 0; i < 8; i++) a += longint'(C[k][i] * (pix[r][i] - 128));
                t[r][k] = int'(rnd_sat(a, 2, 17));
            end
        for (int c = 0; c < 8; c++)
            for (int k = 0; k < 8; k++) begin
                a = 0;
                for (int r = 0; r < 8; r++) a += longint'(C[k][r]) * longint'(t[r][c]);
                exp9[c][k] = int'(rnd_sat(a, 9, 16));
                exp7[c][k] = int'(rnd_sat(a, 7, 16));
            end
    endfunction

    function automatic void chk(input string name, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            rows = 0; exp_col = 0; n8 = 0; done_exp = 1'b0;
        end else begin
            chk("in_ready", longint'(in_ready), longint'(rows < 8));
            chk("busy", longint'(busy), longint'(rows != 0));
            chk("block_done", longint'(block_done), longint'(done_exp));
            chk("valid_pair", longint'(out_valid7), longint'(out_valid));
            if (block_done) done_cyc.push_back(cyc);
            done_exp = 1'b0;
            if (rows < 8) chk("idle_valid", longint'(out_valid), 0);
            else begin
                if (n8 == 0) chk("valid_too_early", longint'(out_valid), 0);
                if (n8 == 1) chk("first_valid", longint'(out_valid), 1);
                n8++;
            end
            if (out_valid) begin
                chk("out_col", longint'(out_col), exp_col);
                chk("out_col7", longint'(out_col7), exp_col);
                for (int k = 0; k < 8; k++) begin
                    chk($sformatf("y9[%0d][%0d]", k, exp_col), int'($signed(out_data[k*16 +: 16])), exp9[exp_col][k]);
                    chk($sformatf("y7[%0d][%0d]", k, exp_col), int'($signed(out_data7[k*16 +: 16])), exp7[exp_col][k]);
                end
                if (out_col == 3'd0) begin
                    cap9 = int'($signed(out_data[15:0]));
                    cap7 = int'($signed(out_data7[15:0]));
                end
            end
            if (in_valid && rows < 8) begin
                for (int i = 0; i < 8; i++) pix[rows][i] = int'(in_data[i*8 +: 8]);
                rows++;
                if (rows == 8) begin build(); n8 = 0; end
            end
            if (out_valid && out_ready) begin
                exp_col++;
                if (exp_col == 8) begin exp_col = 0; rows = 0; done_exp = 1'b1; end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rows(input int n, input bit rnd);
        int r = 0, g = 0;
        while (r < n && g < 200) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(blk[r][i]);
            @(negedge clk);
            if (in_valid && in_ready) r++;
            g++;
            step();
        end
        if (r < n) chk("row_timeout", r, n);
    endtask

    task automatic drain(input bit stall, input bit rnd);
        int g = 0, st = 0;
        bit fin = 1'b0;
        while (!fin && g < 200) begin
            in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data   = {$urandom(), $urandom()};
            out_ready = !(stall && out_valid && out_col == 3'd3 && st < 5);
            if (!out_ready) st++;
            @(negedge clk);
            fin = out_valid && out_ready && out_col == 3'd7;
            g++;
            step();
        end
        if (!fin) chk("drain_timeout", 0, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic run_block(input bit rnd, input bit stall);
        send_rows(8, rnd);
        drain(stall, rnd);
    endtask

    task automatic fill(input int v);
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < 8; i++) blk[r][i] = v < 0 ? int'($urandom_range(0, 255)) : v;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(|out_data), 0);
        chk("rst_out_col", longint'(out_col), 0);
        chk("rst_block_done", longint'(block_done), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        step();
        rst_n = 1'b1;

        fill(128);
        run_block(1'b0, 1'b0);
        chk("model_flat_zero", exp9[4][6], 0);
        chk("dut_flat_dc", cap9, 0);

        fill(255);
        run_block(1'b0, 1'b0);
        chk("model_dc", exp9[0][0], 16256);
        chk("model7_dc", exp7[0][0], 32767);
        chk("dut_dc", cap9, 16256);
        chk("dut7_dc_pos_sat", cap7, 32767);

        fill(0);
        run_block(1'b0, 1'b0);
        chk("model7_neg_sat", exp7[0][0], -32768);
        chk("dut_neg_dc", cap9, -16384);
        chk("dut7_neg_sat", cap7, -32768);

        fill(128);
        blk[0][0] = 255;
        run_block(1'b0, 1'b0);
        chk("model_imp_00", exp9[0][0], 254);
        chk("model_imp_10", exp9[0][1], 353);
        chk("model_imp_01", exp9[1][0], 353);
        chk("dut_imp_dc", cap9, 254);

        for (int b = 0; b < 2; b++) begin
            fill(-1);
            run_block(1'b1, 1'b1);
        end

        fill(-1);
        send_rows(4, 1'b0);
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        run_block(1'b0, 1'b0);

        repeat (3) step();
        done_cyc.delete();
        for (int b = 0; b < 3; b++) begin
            fill(-1);
            run_block(1'b0, 1'b0);
        end
        repeat (3) step();
        chk("done_count", done_cyc.size(), 3);
        if (done_cyc.size() >= 3) begin
            chk("period_0_1", done_cyc[1] - done_cyc[0], 17);
            chk("period_1_2", done_cyc[2] - done_cyc[1], 17);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
